dot_accum_norm: RTL and testbench
=================================

Name: dot_accum_norm

Overview:
- Sits directly downstream of the exponent-alignment stage in the floating-point dot-product datapath.
- Consumes N aligned, two's-complement extended mantissas and their shared maximum exponent.
- Sums the mantissas lane-serially, LANES per cycle, then normalizes the sum back to sign/exponent/mantissa form.
- Uses valid/ready handshakes on both sides so the wide input bus never needs a local copy.

Parameters:
N, 1024, number of aligned terms per dot product; must be a multiple of LANES.
LANES, 16, terms added per SUM cycle.
E_WIDTH, 8, exponent width; biased exponent, max code 2^E_WIDTH-1.
M_WIDTH, 23, output mantissa width (hidden one excluded).
X_WIDTH, LOG2(N), guard/extension width used by the aligner.
M_X_WIDTH, 2*X_WIDTH+M_WIDTH+2, width of one aligned term.
ACC_WIDTH, M_X_WIDTH+X_WIDTH, accumulator width; the sum of N terms cannot overflow it.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  e_i/m_i hold a complete aligned vector.
in_ready  output  1  pulses for one cycle on the last SUM beat; the transfer completes then.
e_i  input  E_WIDTH  shared maximum exponent.
m_i  input  M_X_WIDTH*N  term k is in bits [k*M_X_WIDTH +: M_X_WIDTH], signed; 1.0 = 1<<H, where H = M_WIDTH+X_WIDTH.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
s_o  output  1  result sign.
e_o  output  E_WIDTH  result biased exponent.
m_o  output  M_WIDTH  result mantissa, hidden one removed.

Behaviour:
- Reset values: state=IDLE; in_ready=0, out_valid=0, s_o=0, e_o=0, m_o=0; accumulator and beat counter = 0. Reset in any state aborts the operation with no output.
- Upstream must hold e_i/m_i stable while in_valid=1 and in_ready=0.
- FSM states:
  - IDLE: in_ready=0. When in_valid=1: clear acc, latch e_i, set beat=0, go to SUM.
  - SUM: acc += sign-extended sum of the terms beat*LANES .. beat*LANES+LANES-1. beat increments each cycle.
    - When beat=BEATS-1 (BEATS = N/LANES): in_ready=1 combinationally, then go to NORM.
    - in_ready=0 in all other SUM cycles.
  - NORM: single cycle that registers the result:
    - s = acc MSB; mag = |acc|; p = index of the leading one of mag.
    - exp = e_lat + p - H, computed signed with at least E_WIDTH+2 bits.
    - m = mag bits [p-1 : p-M_WIDTH], truncated (round toward zero). If p < M_WIDTH, left-justify and zero-fill.
    - Boundary cases, in priority order:
      - mag=0 -> s=0, e=0, m=0.
      - exp >= 2^E_WIDTH-1 -> e = all ones, m=0, sign kept (saturate to infinity).
      - exp <= 0 -> s=0, e=0, m=0 (flush to zero).
    - Go to OUT.
  - OUT: out_valid=1; s_o/e_o/m_o stay stable until out_ready=1. On out_valid&out_ready go to IDLE. No new vector is started in that same cycle.
- Latency: in_valid seen in IDLE at cycle t -> SUM runs t+1..t+BEATS -> NORM at t+BEATS+1 -> out_valid high from t+BEATS+2.
- Throughput: one vector per BEATS+3 cycles with out_ready tied high.
- Outputs hold their last values after the output handshake until the next NORM; out_valid=0 in that interval.

Test Plan:
(Bench parameters: N=8, LANES=2, X_WIDTH=3, M_WIDTH=23, M_X_WIDTH=31, H=26, BEATS=4.)
1. All 8 terms = 1<<26, e_i=127 -> sum = 1<<29, p=29; out s=0, e=130, m=0. out_valid at t+6; in_ready high exactly at t+4.
2. term0 = 3<<25 (+1.5), term1 = -(1<<26) (-1.0), rest 0, e_i=127 -> s=0, e=126, m=0.
3. term0 = -(3<<25), rest 0, e_i=100 -> s=1, e=100, m=0x400000. Also: term0 = +1<<26 and term1 = -(1<<26) -> s=0, e=0, m=0.
4. All terms = 1<<26, e_i=254 -> exp=257, saturates: s=0, e=255, m=0. Single term 1<<24 with e_i=1 -> exp=-1, flushed to s=0, e=0, m=0.
5. out_ready held low 5 cycles during OUT -> out_valid and outputs stable the whole time; in_ready stays 0 while in_valid is held high. The next vector's SUM starts only after the output handshake plus the IDLE cycle.
6. reset asserted for 1 cycle during SUM beat 2 -> next cycle state=IDLE and all outputs 0. No out_valid follows. A fresh vector afterwards produces the correct result from test 1.

Source files
------------

// File: rtl/dot_accum_norm.sv
// Lane-serial accumulator for aligned dot-product terms, followed by a single-cycle
// normalizer that repacks the signed sum into sign/biased-exponent/mantissa form.
module dot_accum_norm #(
  parameter int N         = 1024,
  parameter int LANES     = 16,
  parameter int E_WIDTH   = 8,
  parameter int M_WIDTH   = 23,
  parameter int X_WIDTH   = $clog2(N),
  parameter int M_X_WIDTH = 2*X_WIDTH + M_WIDTH + 2,
  parameter int ACC_WIDTH = M_X_WIDTH + X_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [E_WIDTH-1:0]     e_i,
  input  logic [M_X_WIDTH*N-1:0] m_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   s_o,
  output logic [E_WIDTH-1:0]     e_o,
  output logic [M_WIDTH-1:0]     m_o
);

  localparam int BEATS   = N / LANES;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int H       = M_WIDTH + X_WIDTH;
  localparam int P_W     = $clog2(ACC_WIDTH);
  localparam int SLICE_W = LANES * M_X_WIDTH;
  localparam int E_MAX   = (1 << E_WIDTH) - 1;

  typedef enum logic [1:0] {
    IDLE,
    SUM,
    NORM,
    OUT
  } state_t;

  state_t                 state, state_nxt;
  logic [BEAT_W-1:0]      beat;
  logic [ACC_WIDTH-1:0]   acc;
  logic [E_WIDTH-1:0]     e_lat;

  logic [SLICE_W-1:0]     slice;
  logic [ACC_WIDTH-1:0]   lane_sum;
  logic [ACC_WIDTH-1:0]   mag;
  logic [P_W-1:0]         p;
  int                     exp_i;
  logic                   nxt_s;
  logic [E_WIDTH-1:0]     nxt_e;
  logic [M_WIDTH-1:0]     nxt_m;

  // The wide input bus is read in place; only the current beat's lanes are selected.
  assign slice = m_i[int'(beat)*SLICE_W +: SLICE_W];

  // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_sum = lane_sum + ACC_WIDTH'($signed(slice[l*M_X_WIDTH +: M_X_WIDTH]));
    end
  end

  // Normalization: magnitude, leading-one position, exponent rebias and boundary cases.
  always_comb begin
    mag = acc[ACC_WIDTH-1] ? -acc : acc;
    p   = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (mag[i]) p = P_W'(i);
    end
    exp_i = int'(e_lat) + int'(p) - H;
    nxt_s = acc[ACC_WIDTH-1];
    nxt_e = E_WIDTH'(exp_i);
    // Leading one moved to the MSB, then the bits just below it become the mantissa.
    nxt_m = M_WIDTH'((mag << (ACC_WIDTH - 1 - int'(p))) >> (ACC_WIDTH - 1 - M_WIDTH));
    if (mag == '0) begin
      nxt_s = 1'b0;
      nxt_e = '0;
      nxt_m = '0;
    end else if (exp_i >= E_MAX) begin
      nxt_e = '1;
      nxt_m = '0;
    end else if (exp_i <= 0) begin
      nxt_s = 1'b0;
      nxt_e = '0;
      nxt_m = '0;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: if (in_valid) state_nxt = SUM;
      SUM: begin
        if (beat == BEAT_W'(BEATS - 1)) begin
          in_ready  = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM: state_nxt = OUT;
      OUT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = (state == OUT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      beat  <= '0;
      acc   <= '0;
      e_lat <= '0;
      s_o   <= 1'b0;
      e_o   <= '0;
      m_o   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            e_lat <= e_i;
            beat  <= '0;
          end
        end
        SUM: begin
          acc  <= acc + lane_sum;
          beat <= beat + 1'b1;
        end
        NORM: begin
          s_o <= nxt_s;
          e_o <= nxt_e;
          m_o <= nxt_m;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accum_norm.sv
// Directed and randomized checks of dot_accum_norm against an arithmetic reference model.
module tb_dot_accum_norm;

  localparam int N     = 8;
  localparam int LANES = 2;
  localparam int X_W   = 3;
  localparam int M_W   = 23;
  localparam int E_W   = 8;
  localparam int MXW   = 2*X_W + M_W + 2;
  localparam int H     = M_W + X_W;
  localparam int BEATS = N / LANES;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [E_W-1:0]   e_i;
  logic [MXW*N-1:0] m_i;
  logic             out_valid;
  logic             out_ready;
  logic             s_o;
  logic [E_W-1:0]   e_o;
  logic [M_W-1:0]   m_o;

  int     n_vec = 0;
  int     n_err = 0;
  longint terms [N];

  dot_accum_norm #(
    .N(N), .LANES(LANES), .E_WIDTH(E_W), .M_WIDTH(M_W), .X_WIDTH(X_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .e_i(e_i), .m_i(m_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_o(s_o), .e_o(e_o), .m_o(m_o)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued reasoning with plain integers -- sum, find MSB, rebias, truncate.
  function automatic void model(input logic [E_W-1:0] e, output logic s,
                                output logic [E_W-1:0] eo, output logic [M_W-1:0] mo);
    longint sum, mag;
    int p, ex;
    sum = 0;
    for (int k = 0; k < N; k++) sum += terms[k];
    s = 1'b0; eo = '0; mo = '0;
    if (sum == 0) return;
    mag = (sum < 0) ? -sum : sum;
    p = 0;
    for (int i = 0; i < 63; i++) if (((mag >> i) & 64'd1) != 0) p = i;
    ex = int'(e) + p - H;
    if (ex >= 255) begin
      s  = (sum < 0);
      eo = 8'hFF;
    end else if (ex > 0) begin
      s  = (sum < 0);
      eo = ex[7:0];
      mo = (p >= M_W) ? M_W'(mag >> (p - M_W)) : M_W'(mag << (M_W - p));
    end
  endfunction

  task automatic pack();
    for (int k = 0; k < N; k++) m_i[k*MXW +: MXW] = terms[k][MXW-1:0];
  endtask

  task automatic set_all(input longint v);
    for (int k = 0; k < N; k++) terms[k] = v;
  endtask

  // Presents one vector starting in an IDLE cycle and follows it through the output handshake.
  task automatic run_vec(input logic [E_W-1:0] e, input int stall, input bit keep_valid,
                         input string tag);
    logic           xs;
    logic [E_W-1:0] xe;
    logic [M_W-1:0] xm;
    int  ready_k, ready_cnt, valid_k;
    bit  drop;
    model(e, xs, xe, xm);
    pack();
    e_i       = e;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    ready_k = -1; ready_cnt = 0; valid_k = -1; drop = 1'b0;
    for (int k = 1; k <= 40 && valid_k < 0; k++) begin
      @(posedge clock); #1;
      if (drop) begin
        in_valid = keep_valid;
        drop     = 1'b0;
      end
      if (in_ready) begin
        ready_cnt++;
        if (ready_k < 0) ready_k = k;
        drop = 1'b1;
      end
      if (out_valid) valid_k = k;
    end
    check({tag, " in_ready cycle"}, 64'(ready_k), 64'(BEATS));
    check({tag, " in_ready pulses"}, 64'(ready_cnt), 64'd1);
    check({tag, " out_valid latency"}, 64'(valid_k), 64'(BEATS + 2));
    check({tag, " s_o"}, 64'(s_o), 64'(xs));
    check({tag, " e_o"}, 64'(e_o), 64'(xe));
    check({tag, " m_o"}, 64'(m_o), 64'(xm));
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      check({tag, " stall out_valid"}, 64'(out_valid), 64'd1);
      check({tag, " stall result"}, 64'({s_o, e_o, m_o}), 64'({xs, xe, xm}));
      check({tag, " stall in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    check({tag, " idle out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " idle held result"}, 64'({s_o, e_o, m_o}), 64'({xs, xe, xm}));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; e_i = '0; m_i = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset result", 64'({s_o, e_o, m_o}), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // All ones-point-zero terms: sum 8.0
    set_all(longint'(1) << H);
    run_vec(8'd127, 0, 1'b0, "t1 sum8");

    // +1.5 - 1.0 = 0.5
    set_all(0);
    terms[0] = longint'(3) << (H - 1);
    terms[1] = -(longint'(1) << H);
    run_vec(8'd127, 0, 1'b0, "t2 half");

    // -1.5, then exact cancellation
    set_all(0);
    terms[0] = -(longint'(3) << (H - 1));
    run_vec(8'd100, 0, 1'b0, "t3 neg");
    terms[0] = longint'(1) << H;
    terms[1] = -(longint'(1) << H);
    run_vec(8'd100, 0, 1'b0, "t3 cancel");

    // Saturate to infinity, then flush to zero
    set_all(longint'(1) << H);
    run_vec(8'd254, 0, 1'b0, "t4 sat");
    set_all(0);
    terms[0] = longint'(1) << (H - 2);
    run_vec(8'd1, 0, 1'b0, "t4 flush");

    // Output back-pressure with the next vector already waiting
    set_all(longint'(1) << H);
    run_vec(8'd127, 5, 1'b1, "t5 stall");
    run_vec(8'd127, 0, 1'b0, "t5 next");

    // Reset in the middle of SUM beat 2
    set_all(longint'(1) << H);
    pack();
    e_i = 8'd127; in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; in_valid = 1'b0;
    check("t6 reset out_valid", 64'(out_valid), 64'd0);
    check("t6 reset in_ready", 64'(in_ready), 64'd0);
    check("t6 reset result", 64'({s_o, e_o, m_o}), 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      check("t6 no output after abort", 64'(out_valid), 64'd0);
    end
    run_vec(8'd127, 0, 1'b0, "t6 fresh");

    // Randomized vectors over a wide range of magnitudes, signs and exponents
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < N; k++) begin
        longint v;
        v = longint'($urandom_range(0, 32'd268435456)) >> $urandom_range(0, 28);
        if ($urandom_range(0, 1) == 1) v = -v;
        terms[k] = v;
      end
      run_vec(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
